// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue front-end: op codes, rounding mode,
// status flag bit positions and tag width.
package fpu_pkg;

    localparam logic [2:0] FPU_OP_ADD = 3'd0;
    localparam logic [2:0] FPU_OP_SUB = 3'd1;
    localparam logic [2:0] FPU_OP_MUL = 3'd2;
    localparam logic [2:0] FPU_OP_DIV = 3'd3;

    localparam logic [1:0] RMODE_NEAREST_EVEN = 2'd0;

    // Bit positions inside the packed flag word {snan,...,zero}
    localparam int NUM_FLAGS        = 8;
    localparam int FLAG_ZERO        = 0;
    localparam int FLAG_DIV_BY_ZERO = 1;
    localparam int FLAG_UNDERFLOW   = 2;
    localparam int FLAG_OVERFLOW    = 3;
    localparam int FLAG_INE         = 4;
    localparam int FLAG_INF         = 5;
    localparam int FLAG_QNAN        = 6;
    localparam int FLAG_SNAN        = 7;

    localparam int TAG_W = 8;

    typedef logic [NUM_FLAGS-1:0] fpu_flags_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
// DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and count; simultaneous push+pop leaves the count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count state; reset empties the FIFO
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Valid/ready front-end for a fixed-latency, non-stallable fpu core.
// Commands are queued, issued one per clock into registered fpu inputs,
// tracked through a LATENCY+1 deep valid pipe, and their results plus flags
// captured into a result FIFO. A credit check (pipe occupancy + result
// FIFO occupancy < RES_DEPTH) guarantees the result FIFO never overflows.
// Sustaining one op per clock with res_ready high needs RES_DEPTH >= LATENCY+2.
// Optional: define FPU_ISSUE_TAG_EN to carry an 8-bit tag (in_tag/res_tag)
// alongside each op.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int BIT_SIZE  = 31,
    parameter int LATENCY   = 4,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [1:0]          in_rmode,
    input  logic [BIT_SIZE:0]   in_opa,
    input  logic [BIT_SIZE:0]   in_opb,
`ifdef FPU_ISSUE_TAG_EN
    input  logic [TAG_W-1:0]    in_tag,
    output logic [TAG_W-1:0]    res_tag,
`endif
    output logic [2:0]          fpu_op,
    output logic [1:0]          fpu_rmode,
    output logic [BIT_SIZE:0]   opa,
    output logic [BIT_SIZE:0]   opb,
    input  logic [BIT_SIZE:0]   out,
    input  logic                snan,
    input  logic                qnan,
    input  logic                inf,
    input  logic                ine,
    input  logic                overflow,
    input  logic                underflow,
    input  logic                div_by_zero,
    input  logic                zero,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [BIT_SIZE:0]   res_data,
    output logic [7:0]          res_flags
);

    localparam int W = BIT_SIZE + 1;
`ifdef FPU_ISSUE_TAG_EN
    localparam int CMD_W = TAG_W + 5 + 2 * W;
    localparam int RES_W = TAG_W + W + NUM_FLAGS;
`else
    localparam int CMD_W = 5 + 2 * W;
    localparam int RES_W = W + NUM_FLAGS;
`endif

    // ---------------- command FIFO ----------------
    logic                          cmd_full, cmd_empty;
    logic [$clog2(CMD_DEPTH):0]    cmd_count;
    logic [CMD_W-1:0]              cmd_wdata, cmd_rdata;
    logic [2:0]                    cmd_op;
    logic [1:0]                    cmd_rmode;
    logic [W-1:0]                  cmd_opa, cmd_opb;
    logic                          issue;

`ifdef FPU_ISSUE_TAG_EN
    logic [TAG_W-1:0]              cmd_tag;
    assign cmd_wdata = {in_tag, in_op, in_rmode, in_opa, in_opb};
    assign cmd_tag   = cmd_rdata[2*W+5 +: TAG_W];
`else
    assign cmd_wdata = {in_op, in_rmode, in_opa, in_opb};
`endif
    assign cmd_op    = cmd_rdata[2*W+2 +: 3];
    assign cmd_rmode = cmd_rdata[2*W   +: 2];
    assign cmd_opa   = cmd_rdata[W     +: W];
    assign cmd_opb   = cmd_rdata[0     +: W];

    // in_ready depends only on FIFO state, never on in_valid
    assign in_ready = !cmd_full;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (in_valid),
        .wdata_i (cmd_wdata),
        .pop_i   (issue),
        .rdata_o (cmd_rdata),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

    // ---------------- credit / issue ----------------
    logic [LATENCY:0]              vld_pipe_q;
    logic [$clog2(RES_DEPTH):0]    res_count;
    logic                          res_full, res_empty, res_pop;
    int                            outstanding;

    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;

    // Ops in the pipe or waiting in the result FIFO, net of a result leaving this edge
    always_comb begin
        outstanding = 0;
        for (int i = 0; i <= LATENCY; i++) outstanding += int'(vld_pipe_q[i]);
        outstanding += int'(res_count);
        if (res_pop) outstanding -= 1;
    end

    assign issue = !cmd_empty && (outstanding < RES_DEPTH);

    logic [2:0]   fpu_op_q;
    logic [1:0]   fpu_rmode_q;
    logic [W-1:0] opa_q, opb_q;

    // fpu input registers: load on issue, hold last value when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_op_q    <= FPU_OP_ADD;
            fpu_rmode_q <= RMODE_NEAREST_EVEN;
            opa_q       <= '0;
            opb_q       <= '0;
        end else if (issue) begin
            fpu_op_q    <= cmd_op;
            fpu_rmode_q <= cmd_rmode;
            opa_q       <= cmd_opa;
            opb_q       <= cmd_opb;
        end
    end

    assign fpu_op    = fpu_op_q;
    assign fpu_rmode = fpu_rmode_q;
    assign opa       = opa_q;
    assign opb       = opb_q;

    // Valid pipe: stage 0 mirrors the issue register, last stage marks out/flags valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= {vld_pipe_q[LATENCY-1:0], issue};
    end

`ifdef FPU_ISSUE_TAG_EN
    logic [LATENCY:0][TAG_W-1:0] tag_pipe_q;

    // Tag travels in lockstep with the valid pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tag_pipe_q <= '0;
        else     tag_pipe_q <= {tag_pipe_q[LATENCY-1:0], cmd_tag};
    end
`endif

    // ---------------- result FIFO ----------------
    fpu_flags_t       cap_flags;
    logic [RES_W-1:0] res_wdata, res_rdata;

    // Pack the individual fpu status lines into the flag word
    always_comb begin
        cap_flags                   = '0;
        cap_flags[FLAG_SNAN]        = snan;
        cap_flags[FLAG_QNAN]        = qnan;
        cap_flags[FLAG_INF]         = inf;
        cap_flags[FLAG_INE]         = ine;
        cap_flags[FLAG_OVERFLOW]    = overflow;
        cap_flags[FLAG_UNDERFLOW]   = underflow;
        cap_flags[FLAG_DIV_BY_ZERO] = div_by_zero;
        cap_flags[FLAG_ZERO]        = zero;
    end

`ifdef FPU_ISSUE_TAG_EN
    assign res_wdata = {tag_pipe_q[LATENCY], out, cap_flags};
    assign res_tag   = res_rdata[W+NUM_FLAGS +: TAG_W];
`else
    assign res_wdata = {out, cap_flags};
`endif
    assign res_data  = res_rdata[NUM_FLAGS +: W];
    assign res_flags = res_rdata[0 +: NUM_FLAGS];

    sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (vld_pipe_q[LATENCY]),
        .wdata_i (res_wdata),
        .pop_i   (res_pop),
        .rdata_o (res_rdata),
        .full_o  (res_full),
        .empty_o (res_empty),
        .count_o (res_count)
    );

    // Status outputs not needed here: cmd occupancy is implied by full/empty,
    // and the credit check keeps the result FIFO from ever being pushed while full
    logic unused_fifo_status;
    assign unused_fifo_status = &{1'b0, cmd_count, res_full};

endmodule
